// File: rtl/riscv_hwloop_controller_if.sv
// Bundle between the hardware-loop controller, the ID stage and the hwloop register file.
// The slave modport is the controller's view; the master modport is the surrounding pipeline's.
interface riscv_hwloop_controller_if #(
    parameter int N_REGS = 2
);
    logic [31:0]             current_pc_i;
    logic                    pc_valid_i;
    logic                    id_valid_i;
    logic                    flush_i;
    logic [N_REGS-1:0][31:0] hwlp_start_addr_i;
    logic [N_REGS-1:0][31:0] hwlp_end_addr_i;
    logic [N_REGS-1:0][31:0] hwlp_counter_i;
    logic [N_REGS-1:0]       hwlp_dec_cnt_o;
    logic                    hwlp_jump_o;
    logic [31:0]             hwlp_targ_addr_o;
    logic [N_REGS-1:0]       hwlp_active_o;

    modport master (
        output current_pc_i, pc_valid_i, id_valid_i, flush_i,
        output hwlp_start_addr_i, hwlp_end_addr_i, hwlp_counter_i,
        input  hwlp_dec_cnt_o, hwlp_jump_o, hwlp_targ_addr_o, hwlp_active_o
    );

    modport slave (
        input  current_pc_i, pc_valid_i, id_valid_i, flush_i,
        input  hwlp_start_addr_i, hwlp_end_addr_i, hwlp_counter_i,
        output hwlp_dec_cnt_o, hwlp_jump_o, hwlp_targ_addr_o, hwlp_active_o
    );
endinterface

// File: rtl/riscv_hwloop_controller.sv
// Hardware-loop controller: detects the end of a loop body at the ID-stage PC, requests the
// counter decrement and redirects fetch to the loop start, holding its decision across stalls.
module riscv_hwloop_controller #(
    parameter int N_REGS     = 2,
    parameter int N_REG_BITS = $clog2(N_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    riscv_hwloop_controller_if.slave hwlp
);

    localparam int SEL_W = (N_REG_BITS > 0) ? N_REG_BITS : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]        r_state;
    logic [SEL_W-1:0]  r_sel_q;
    logic              r_jump_q;
    logic [31:0]       r_targ_q;

    logic [N_REGS-1:0] w_match;
    logic [N_REGS-1:0] w_active;
    logic              w_any;
    logic [SEL_W-1:0]  w_sel;
    logic              w_found;
    logic [31:0]       w_sel_cnt;
    logic [31:0]       w_sel_start;
    logic              w_jump_sel;
    logic              w_jump;
    logic [31:0]       w_targ;
    logic [N_REGS-1:0] w_dec;

    function automatic logic [N_REGS-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_REGS-1:0] v;
        v = '0;
        for (int unsigned k = 0; k < N_REGS; k++) begin
            if (idx == SEL_W'(k)) begin
                v[k] = 1'b1;
            end
        end
        return v;
    endfunction

    // A zero counter never matches, so the register file can never wrap below zero.
    always_comb begin
        w_match  = '0;
        w_active = '0;
        for (int unsigned k = 0; k < N_REGS; k++) begin
            w_active[k] = (hwlp.hwlp_counter_i[k] != 32'h0);
            w_match[k]  = hwlp.pc_valid_i
                        && (hwlp.current_pc_i == hwlp.hwlp_end_addr_i[k])
                        && w_active[k];
        end
    end

    // Lowest index wins, so the inner loop (0) takes precedence on a shared end address.
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < N_REGS; k++) begin
            if (w_match[k] && !w_found) begin
                w_sel   = SEL_W'(k);
                w_found = 1'b1;
            end
        end
    end

    assign w_any       = |w_match;
    assign w_sel_cnt   = hwlp.hwlp_counter_i[w_sel];
    assign w_sel_start = hwlp.hwlp_start_addr_i[w_sel];
    assign w_jump_sel  = (w_sel_cnt > 32'd1);

    // Decrement is only presented while the instruction retires, so a stalled match
    // never leaves a standing request; flush overrides everything in either state.
    always_comb begin
        w_jump = 1'b0;
        w_targ = '0;
        w_dec  = '0;
        if (r_state == S_IDLE) begin
            w_jump = w_any && w_jump_sel;
            w_targ = w_any ? w_sel_start : 32'h0;
            w_dec  = w_any ? onehot(w_sel) : '0;
        end else begin
            w_jump = r_jump_q;
            w_targ = r_targ_q;
            w_dec  = onehot(r_sel_q);
        end
        if (!hwlp.id_valid_i) begin
            w_dec = '0;
        end
        if (hwlp.flush_i) begin
            w_dec  = '0;
            w_jump = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_sel_q  <= '0;
            r_jump_q <= 1'b0;
            r_targ_q <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any && !hwlp.id_valid_i && !hwlp.flush_i) begin
                        r_state  <= S_WAIT;
                        r_sel_q  <= w_sel;
                        r_jump_q <= w_jump_sel;
                        r_targ_q <= w_sel_start;
                    end
                end
                S_WAIT: begin
                    if (hwlp.id_valid_i || hwlp.flush_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign hwlp.hwlp_dec_cnt_o   = w_dec;
    assign hwlp.hwlp_jump_o      = w_jump;
    assign hwlp.hwlp_targ_addr_o = w_targ;
    assign hwlp.hwlp_active_o    = w_active;

endmodule

// File: tb/tb_riscv_hwloop_controller.sv
// Directed bench for riscv_hwloop_controller with hand-computed expected outputs.
module tb_riscv_hwloop_controller;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    riscv_hwloop_controller_if #(.N_REGS(2)) bus ();

    riscv_hwloop_controller #(.N_REGS(2), .N_REG_BITS(1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hwlp (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        assert ($onehot0(bus.hwlp_dec_cnt_o))
        else $error("dec_cnt_o not one-hot-or-zero: %b", bus.hwlp_dec_cnt_o);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic jump, input logic [31:0] targ,
                             input logic [1:0] dec);
        @(negedge clk);
        check_eq({tag, ".jump"}, {31'h0, bus.hwlp_jump_o}, {31'h0, jump});
        check_eq({tag, ".targ"}, bus.hwlp_targ_addr_o, targ);
        check_eq({tag, ".dec"}, {30'h0, bus.hwlp_dec_cnt_o}, {30'h0, dec});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        bus.current_pc_i      = 32'h0;
        bus.pc_valid_i        = 1'b0;
        bus.id_valid_i        = 1'b0;
        bus.flush_i           = 1'b0;
        bus.hwlp_start_addr_i = '0;
        bus.hwlp_end_addr_i   = '0;
        bus.hwlp_counter_i    = '0;

        check_out("reset", 1'b0, 32'h0, 2'b00);
        check_eq("reset.active", {30'h0, bus.hwlp_active_o}, 32'h0);
        tick();
        rst_n = 1'b1;

        // basic jump with zero-latency decrement
        bus.hwlp_end_addr_i[0]   = 32'h100;
        bus.hwlp_start_addr_i[0] = 32'h0F0;
        bus.hwlp_counter_i[0]    = 32'd3;
        bus.hwlp_end_addr_i[1]   = 32'h500;
        bus.hwlp_start_addr_i[1] = 32'h480;
        bus.current_pc_i = 32'h100;
        bus.pc_valid_i   = 1'b1;
        bus.id_valid_i   = 1'b1;
        check_out("cnt3", 1'b1, 32'h0F0, 2'b01);
        check_eq("cnt3.active", {30'h0, bus.hwlp_active_o}, 32'h1);
        tick();
        bus.current_pc_i = 32'h104;
        check_out("stay_idle", 1'b0, 32'h0, 2'b00);
        tick();

        // counter 1 falls through, counter 0 never matches
        bus.current_pc_i = 32'h100;
        bus.hwlp_counter_i[0] = 32'd1;
        check_out("cnt1", 1'b0, 32'h0F0, 2'b01);
        tick();
        bus.hwlp_counter_i[0] = 32'd0;
        check_out("cnt0", 1'b0, 32'h0, 2'b00);
        check_eq("cnt0.active", {30'h0, bus.hwlp_active_o}, 32'h0);
        tick();

        // shared end address: inner loop wins; outer selected only when inner is exhausted
        bus.hwlp_end_addr_i[0]   = 32'h200;
        bus.hwlp_end_addr_i[1]   = 32'h200;
        bus.hwlp_start_addr_i[0] = 32'h1F0;
        bus.hwlp_start_addr_i[1] = 32'h180;
        bus.hwlp_counter_i[0]    = 32'd2;
        bus.hwlp_counter_i[1]    = 32'd5;
        bus.current_pc_i = 32'h200;
        check_out("nest", 1'b1, 32'h1F0, 2'b01);
        check_eq("nest.active", {30'h0, bus.hwlp_active_o}, 32'h3);
        tick();
        bus.hwlp_counter_i[0] = 32'd0;
        check_out("outer", 1'b1, 32'h180, 2'b10);
        tick();

        // stall: decision latched in WAIT, inputs rewritten underneath
        bus.hwlp_end_addr_i[0]   = 32'h100;
        bus.hwlp_start_addr_i[0] = 32'h0F0;
        bus.hwlp_counter_i[0]    = 32'd3;
        bus.hwlp_counter_i[1]    = 32'd0;
        bus.current_pc_i = 32'h100;
        bus.id_valid_i   = 1'b0;
        check_out("stall0", 1'b1, 32'h0F0, 2'b00);
        tick();
        bus.hwlp_end_addr_i[0]   = 32'h300;
        bus.hwlp_start_addr_i[0] = 32'h777;
        bus.hwlp_counter_i[0]    = 32'd1;
        bus.pc_valid_i = 1'b0;
        check_out("stall1", 1'b1, 32'h0F0, 2'b00);
        tick();
        check_out("stall2", 1'b1, 32'h0F0, 2'b00);
        tick();
        bus.id_valid_i = 1'b1;
        check_out("stall_ret", 1'b1, 32'h0F0, 2'b01);
        tick();
        bus.pc_valid_i = 1'b1;
        check_out("stall_idle", 1'b0, 32'h0, 2'b00);
        tick();

        // flush beats id_valid in WAIT
        bus.hwlp_end_addr_i[0]   = 32'h100;
        bus.hwlp_start_addr_i[0] = 32'h0F0;
        bus.hwlp_counter_i[0]    = 32'd3;
        bus.id_valid_i = 1'b0;
        check_out("fl_enter", 1'b1, 32'h0F0, 2'b00);
        tick();
        bus.flush_i    = 1'b1;
        bus.id_valid_i = 1'b1;
        check_out("flush", 1'b0, 32'h0F0, 2'b00);
        tick();
        bus.flush_i    = 1'b0;
        bus.id_valid_i = 1'b0;
        bus.pc_valid_i = 1'b0;
        check_out("fl_idle", 1'b0, 32'h0, 2'b00);
        tick();

        // reset while waiting discards the pending decision
        bus.pc_valid_i = 1'b1;
        check_out("rs_enter", 1'b1, 32'h0F0, 2'b00);
        tick();
        bus.pc_valid_i = 1'b0;
        bus.id_valid_i = 1'b1;
        rst_n = 1'b0;
        check_out("rs_wait", 1'b0, 32'h0, 2'b00);
        tick();
        rst_n = 1'b1;
        check_out("rs_idle", 1'b0, 32'h0, 2'b00);
        tick();

        // single-instruction body, counter modelled 4,3,2,1,0
        bus.hwlp_start_addr_i[0] = 32'h40;
        bus.hwlp_end_addr_i[0]   = 32'h40;
        bus.current_pc_i = 32'h40;
        bus.pc_valid_i   = 1'b1;
        bus.id_valid_i   = 1'b1;
        for (int i = 4; i >= 0; i--) begin
            bus.hwlp_counter_i[0] = 32'(i);
            check_out($sformatf("single%0d", i), i > 1, (i > 0) ? 32'h40 : 32'h0,
                      (i > 0) ? 2'b01 : 2'b00);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_hwloop_controller.md
RISCV_HWLOOP_CONTROLLER -- requirements
Module: riscv_hwloop_controller

Interface
REQ-001 SHALL have parameter N_REGS, default 2, number of hardware-loop register sets.
REQ-002 SHALL have parameter N_REG_BITS, default $clog2(N_REGS), register-set index width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port current_pc_i  input  32  PC of the instruction in the ID stage.
REQ-006 SHALL have port pc_valid_i  input  1  current_pc_i holds a live instruction.
REQ-007 SHALL have port id_valid_i  input  1  the ID instruction retires this cycle; same signal drives valid_i of the hwloop register file.
REQ-008 SHALL have port flush_i  input  1  kill the ID instruction (branch, exception, debug).
REQ-009 SHALL have port hwlp_start_addr_i  input  N_REGS x 32  loop start addresses.
REQ-010 SHALL have port hwlp_end_addr_i  input  N_REGS x 32  loop end addresses (last instruction of the body).
REQ-011 SHALL have port hwlp_counter_i  input  N_REGS x 32  remaining iteration counts.
REQ-012 SHALL have port hwlp_dec_cnt_o  output  N_REGS  decrement request to the register file, one-hot or zero.
REQ-013 SHALL have port hwlp_jump_o  output  1  redirect fetch to hwlp_targ_addr_o.
REQ-014 SHALL have port hwlp_targ_addr_o  output  32  jump target (loop start address).
REQ-015 SHALL have port hwlp_active_o  output  N_REGS  bit k = loop k has a nonzero counter.

Function
REQ-016 match[k] SHALL be pc_valid_i AND (current_pc_i == hwlp_end_addr_i[k]) AND (hwlp_counter_i[k] != 0).
REQ-017 The selected loop SHALL be the lowest index with match[k] set, so loop 0 (the inner loop) wins on a shared end address.
REQ-018 jump_sel SHALL be 1 when the selected counter is unsigned > 1; a counter of exactly 1 SHALL fall through with no jump and still decrement.
REQ-019 hwlp_active_o[k] SHALL be (hwlp_counter_i[k] != 0), combinational, in every state.
REQ-020 The FSM SHALL have two states: IDLE and WAIT.
REQ-021 IDLE outputs SHALL be combinational from the current match: jump_o = any match AND jump_sel; targ_addr_o = start_addr[sel]; dec_cnt_o = onehot(sel) when any match, else 0.
REQ-022 IDLE -> WAIT SHALL occur when there is any match, id_valid_i=0 and flush_i=0; sel, jump_sel and start_addr[sel] are latched into sel_q, jump_q and targ_q.
REQ-023 In IDLE, a match with id_valid_i=1 SHALL stay in IDLE; the decrement occurs that cycle with zero latency.
REQ-024 WAIT outputs SHALL come only from the latched values: jump_o = jump_q; targ_addr_o = targ_q; dec_cnt_o = onehot(sel_q).
REQ-025 WAIT outputs SHALL ignore changes on pc_valid_i, the address inputs or the counter inputs, including writes to the loop registers during a stall.
REQ-026 WAIT -> IDLE SHALL occur on id_valid_i=1 (decrement occurs that cycle) or on flush_i=1.
REQ-027 flush_i=1 SHALL force dec_cnt_o=0 and jump_o=0 in the same cycle in either state, and SHALL win over a simultaneous id_valid_i.
REQ-028 When start==end (single-instruction body), the block SHALL re-match the same PC every retiring cycle with no lockout.
REQ-029 hwlp_dec_cnt_o SHALL never have more than one bit set.
REQ-030 The counter value itself SHALL NOT be modified here; wrap below 0 is prevented because counter 0 never matches.

Reset
REQ-031 While rst_n=0: state=IDLE; sel_q=0, jump_q=0, targ_q=32'h0.
REQ-032 Outputs SHALL then follow IDLE combinational rules; with zero counters all outputs are 0.
REQ-033 Reset asserted in WAIT SHALL drop to IDLE immediately and discard the pending decrement.

Verification
REQ-034 end[0]=0x100, start[0]=0x0F0, cnt[0]=3, pc=0x100, id_valid=1 -> jump=1, targ=0x0F0, dec=2'b01 in the same cycle, state stays IDLE.
REQ-035 Same setup with cnt[0]=1 -> jump=0, dec=2'b01; with cnt[0]=0 -> all outputs 0, active[0]=0.
REQ-036 end[0]=end[1]=0x200, cnt[0]=2, cnt[1]=5 -> dec=2'b01, targ=start[0]; loop 1 is untouched.
REQ-037 Match with id_valid=0 for 3 cycles while end[0] is rewritten to 0x300 -> outputs stay at the latched values; dec pulses only in the cycle id_valid=1, then IDLE.
REQ-038 In WAIT, flush=1 and id_valid=1 together -> dec=0, jump=0, state IDLE; rst_n low in WAIT -> IDLE, targ_q=0.
REQ-039 start=end=0x40, cnt=4, id_valid=1 every cycle -> dec pulses in 4 consecutive cycles and jump=1 in the first 3 (counter modelled 4,3,2,1); assertion checks dec one-hot-or-zero throughout.
